// File: rtl/slot_alloc_16.sv
// rtl/slot_alloc_16.sv - 16-entry slot allocator with lowest-free or round-robin search
module slot_alloc_16 #(
    parameter int SEARCH_RR = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        alloc_valid,
    output logic        alloc_ready,
    output logic [3:0]  alloc_idx,
    input  logic        free_valid,
    input  logic [3:0]  free_idx,
    output logic [15:0] busy_map,
    output logic [4:0]  count,
    output logic        full,
    output logic        empty,
    output logic        free_err
);

    logic [3:0]  rr_ptr;
    logic [15:0] free_vec;
    logic [15:0] low_onehot;
    logic [31:0] busy_dbl;
    logic [15:0] rot_free;
    logic [15:0] rot_onehot;
    logic [3:0]  low_enc;
    logic [3:0]  rot_enc;
    logic [3:0]  search_idx;
    logic        fire_alloc;
    logic        fire_free;
    logic        bad_free;
    logic [15:0] grant_mask;
    logic [15:0] release_mask;

    assign full        = (count == 5'd16);
    assign empty       = (count == 5'd0);
    assign alloc_ready = ~full;

    // Lowest set bit isolated as x & -x, giving a one-hot vector to encode.
    assign free_vec   = ~busy_map;
    assign low_onehot = free_vec & (~free_vec + 16'd1);

    // Rotating through a doubled map puts slot rr_ptr+j at bit j.
    assign busy_dbl   = {busy_map, busy_map};
    assign rot_free   = ~busy_dbl[rr_ptr +: 16];
    assign rot_onehot = rot_free & (~rot_free + 16'd1);

    always_comb begin
        low_enc = 4'd0;
        rot_enc = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (low_onehot[i]) low_enc = low_enc | 4'(i);
            if (rot_onehot[i]) rot_enc = rot_enc | 4'(i);
        end
    end

    assign search_idx = (SEARCH_RR != 0) ? (rr_ptr + rot_enc) : low_enc;
    assign alloc_idx  = alloc_ready ? search_idx : 4'd0;

    assign fire_alloc   = alloc_valid & alloc_ready;
    assign fire_free    = free_valid & busy_map[free_idx];
    assign bad_free     = free_valid & ~busy_map[free_idx];
    assign grant_mask   = fire_alloc ? (16'd1 << alloc_idx) : 16'd0;
    assign release_mask = fire_free ? (16'd1 << free_idx) : 16'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_map <= 16'd0;
            count    <= 5'd0;
            rr_ptr   <= 4'd0;
            free_err <= 1'b0;
        end else if (flush) begin
            busy_map <= 16'd0;
            count    <= 5'd0;
            rr_ptr   <= 4'd0;
            free_err <= 1'b0;
        end else begin
            // Grant and release never target the same slot: one is free, the other busy.
            busy_map <= (busy_map | grant_mask) & ~release_mask;
            case ({fire_alloc, fire_free})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            if (fire_alloc) rr_ptr <= alloc_idx + 4'd1;
            free_err <= bad_free;
        end
    end

endmodule

// File: tb/tb_slot_alloc_16.sv
// tb/tb_slot_alloc_16.sv - checks lowest-free and round-robin allocators against a slot-array model
module tb_slot_alloc_16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        alloc_valid = 1'b0;
    logic        free_valid = 1'b0;
    logic [3:0]  free_idx = 4'd0;

    logic        rdy   [2];
    logic [3:0]  gidx  [2];
    logic [15:0] bmap  [2];
    logic [4:0]  cnt   [2];
    logic        fl    [2];
    logic        em    [2];
    logic        ferr  [2];

    int checks = 0;
    int errors = 0;

    bit mb   [2][16];
    int mrr  [2];
    bit merr [2];

    always #5 clk = ~clk;

    slot_alloc_16 #(.SEARCH_RR(0)) u_low (
        .clk(clk), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(rdy[0]), .alloc_idx(gidx[0]),
        .free_valid(free_valid), .free_idx(free_idx),
        .busy_map(bmap[0]), .count(cnt[0]), .full(fl[0]), .empty(em[0]),
        .free_err(ferr[0])
    );

    slot_alloc_16 #(.SEARCH_RR(1)) u_rr (
        .clk(clk), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(rdy[1]), .alloc_idx(gidx[1]),
        .free_valid(free_valid), .free_idx(free_idx),
        .busy_map(bmap[1]), .count(cnt[1]), .full(fl[1]), .empty(em[1]),
        .free_err(ferr[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_count(int k);
        int n = 0;
        for (int i = 0; i < 16; i++) n += mb[k][i];
        return n;
    endfunction

    function automatic logic [15:0] m_map(int k);
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++) v[i] = mb[k][i];
        return v;
    endfunction

    // Slot that would be granted now; 0 when nothing is free.
    function automatic int m_grant(int k);
        if (m_count(k) == 16) return 0;
        for (int j = 0; j < 16; j++) begin
            int s = (k == 0) ? j : (mrr[k] + j) % 16;
            if (!mb[k][s]) return s;
        end
        return 0;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) mb[k][i] = 0;
            mrr[k] = 0;
            merr[k] = 0;
        end
    endtask

    task automatic m_step(bit av, bit fv, int fi, bit fls);
        for (int k = 0; k < 2; k++) begin
            if (fls) begin
                for (int i = 0; i < 16; i++) mb[k][i] = 0;
                mrr[k] = 0;
                merr[k] = 0;
            end else begin
                bit ga = av && (m_count(k) < 16);
                int g  = m_grant(k);
                bit wasbusy = mb[k][fi];
                merr[k] = fv && !wasbusy;
                if (fv && wasbusy) mb[k][fi] = 0;
                if (ga) begin
                    mb[k][g] = 1;
                    mrr[k] = (g + 1) % 16;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            int c = m_count(k);
            chk($sformatf("%s[%0d].ready", tag, k), 32'(rdy[k]), 32'(c != 16));
            chk($sformatf("%s[%0d].idx", tag, k), 32'(gidx[k]), 32'(m_grant(k)));
            chk($sformatf("%s[%0d].busy", tag, k), 32'(bmap[k]), 32'(m_map(k)));
            chk($sformatf("%s[%0d].count", tag, k), 32'(cnt[k]), 32'(c));
            chk($sformatf("%s[%0d].full", tag, k), 32'(fl[k]), 32'(c == 16));
            chk($sformatf("%s[%0d].empty", tag, k), 32'(em[k]), 32'(c == 0));
            chk($sformatf("%s[%0d].ferr", tag, k), 32'(ferr[k]), 32'(merr[k]));
        end
    endtask

    // Drive one cycle: check pre-edge outputs, advance model, cross the edge.
    task automatic cyc(input string tag, input bit av, input bit fv, input int fi, input bit fls);
        alloc_valid = av;
        free_valid  = fv;
        free_idx    = 4'(fi);
        flush       = fls;
        @(negedge clk);
        check_all(tag);
        m_step(av, fv, fi, fls);
        @(posedge clk);
        #1;
        alloc_valid = 0;
        free_valid  = 0;
        flush       = 0;
    endtask

    initial begin
        m_reset();
        @(negedge clk);
        check_all("reset");
        for (int k = 0; k < 2; k++) begin
            chk("reset.ready_const", 32'(rdy[k]), 32'd1);
            chk("reset.empty_const", 32'(em[k]), 32'd1);
        end
        @(posedge clk);
        #1 reset = 0;

        // Fill, then a 17th request that must not be granted
        for (int i = 0; i < 16; i++) begin
            if (i == 0 || i == 15) chk("fill.grant_low", 32'(gidx[0]), 32'(i));
            cyc("fill", 1, 0, 0, 0);
        end
        chk("full.busy", 32'(bmap[0]), 32'hFFFF);
        chk("full.count", 32'(cnt[0]), 32'd16);
        cyc("req17", 1, 0, 0, 0);

        // Simultaneous alloc and release when full
        cyc("simul", 1, 1, 7, 0);
        chk("simul.busy", 32'(bmap[0]), 32'hFF7F);
        chk("simul.count", 32'(cnt[1]), 32'd15);
        chk("simul.next_grant", 32'(gidx[0]), 32'd7);
        cyc("regrant", 1, 0, 0, 0);

        // Flush at 0xFFFF/partial with alloc_valid ignored
        cyc("flush", 1, 0, 0, 1);
        chk("flush.busy", 32'(bmap[0]), 32'h0);

        // Hole reuse and round-robin continuation
        for (int i = 0; i < 4; i++) cyc("a4", 1, 0, 0, 0);
        cyc("free1", 0, 1, 1, 0);
        chk("hole.low_grant", 32'(gidx[0]), 32'd1);
        chk("hole.rr_grant", 32'(gidx[1]), 32'd4);
        cyc("hole", 1, 0, 0, 0);
        chk("hole.busy", 32'(bmap[0]), 32'h000F);
        for (int i = 0; i < 11; i++) cyc("rr_run", 1, 0, 0, 0);
        chk("rr.wrap_grant", 32'(gidx[1]), 32'd1);
        cyc("rr_wrap", 1, 0, 0, 0);

        // Illegal free then legal free
        cyc("flush2", 0, 0, 0, 1);
        cyc("a1", 1, 0, 0, 0);
        cyc("badfree", 0, 1, 5, 0);
        chk("badfree.err", 32'(ferr[0]), 32'd1);
        chk("badfree.busy", 32'(bmap[0]), 32'h0001);
        cyc("goodfree", 0, 1, 0, 0);
        chk("goodfree.err", 32'(ferr[0]), 32'd0);
        cyc("idle", 0, 0, 0, 0);
        // Release of a free slot equal to the grant index: error, alloc still fires
        cyc("same_idx", 1, 1, 0, 0);
        cyc("idle2", 0, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            cyc("rand", ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 45),
                int'($urandom_range(0, 15)), ($urandom_range(0, 99) < 3));
        end

        // Async reset pulse between edges
        for (int i = 0; i < 6; i++) cyc("prefill", 1, 0, 0, 0);
        @(negedge clk);
        #1 reset = 1;
        #1;
        m_reset();
        check_all("async_rst");
        chk("async_rst.busy_const", 32'(bmap[0]), 32'h0);
        chk("async_rst.count_const", 32'(cnt[1]), 32'd0);
        #1 reset = 0;
        @(posedge clk);
        #1;

        for (int n = 0; n < 400; n++) begin
            cyc("rand2", ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                int'($urandom_range(0, 15)), ($urandom_range(0, 99) < 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
